// File: rtl/pc_pkg.sv
// Next-PC mode encodings, shared by pc_unit and the control decoder that
// drives pcSrc.
package pc_pkg;

  localparam int PC_SRC_W = 3;

  localparam logic [PC_SRC_W-1:0] PC_NEXT   = 3'b000;
  localparam logic [PC_SRC_W-1:0] PC_REL    = 3'b001;
  localparam logic [PC_SRC_W-1:0] PC_ABS    = 3'b010;
  localparam logic [PC_SRC_W-1:0] PC_RET    = 3'b011;
  localparam logic [PC_SRC_W-1:0] PC_REG    = 3'b100;
  localparam logic [PC_SRC_W-1:0] PC_CALL   = 3'b101;
  localparam logic [PC_SRC_W-1:0] PC_BR_ABS = 3'b110;
  localparam logic [PC_SRC_W-1:0] PC_BR_SHF = 3'b111;

endpackage

// File: rtl/pc_unit_return_stack.sv
// Circular return-address stack: topPtr_q is the next write slot, so when the
// stack is full that slot holds the oldest entry and a push overwrites it.
module return_stack #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           top_o,
  output logic [$clog2(RAS_DEPTH):0] count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] entries_q [RAS_DEPTH];
  logic [PTR_W-1:0] topPtr_q, topPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             isFull, isEmpty;

  assign isFull      = (count_q == CNT_W'(RAS_DEPTH));
  assign isEmpty     = (count_q == '0);
  assign overflow_o  = push_i & isFull;
  assign underflow_o = pop_i & isEmpty;
  assign count_o     = count_q;
  assign top_o       = entries_q[topPtr_q - PTR_W'(1)];

  // Push and pop never coincide (distinct pcSrc modes); push is given priority.
  // An empty pop leaves pointer and count untouched.
  always_comb begin
    topPtr_d = topPtr_q;
    count_d  = count_q;
    if (push_i) begin
      topPtr_d = topPtr_q + PTR_W'(1);
      if (!isFull) count_d = count_q + CNT_W'(1);
    end else if (pop_i && !isEmpty) begin
      topPtr_d = topPtr_q - PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      topPtr_q <= '0;
      count_q  <= '0;
    end else begin
      topPtr_q <= topPtr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is deliberately not reset; only valid entries are ever read.
  always_ff @(posedge clock) begin
    if (push_i && !reset) entries_q[topPtr_q] <= data_i;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC mux, conditional branch resolution and an
// integrated return-address stack used by CALL/RET.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               RAS_DEPTH = 8,
  parameter int               SHIFT     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       pcWrite,
  input  logic [PC_SRC_W-1:0]        pcSrc,
  input  logic [WIDTH-1:0]           immAddr,
  input  logic [WIDTH-1:0]           mary,
  input  logic                       comp,
  output logic [WIDTH-1:0]           pcOut,
  output logic [WIDTH-1:0]           pcNext,
  output logic [$clog2(RAS_DEPTH):0] rasCount,
  output logic                       rasEmpty,
  output logic                       rasFull,
  output logic                       rasErr
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             rasErr_q, rasErr_d;
  logic [WIDTH-1:0] pcPlusOne, relTarget, shfTarget, rasTop;
  logic             callPush, retPop, rasOverflow, rasUnderflow;

  assign pcPlusOne = pc_q + WIDTH'(1);
  assign relTarget = pc_q + immAddr;
  assign shfTarget = immAddr << SHIFT;

  // Stack side effects only happen on edges where the PC actually advances.
  assign callPush = pcWrite && (pcSrc == PC_CALL);
  assign retPop   = pcWrite && (pcSrc == PC_RET);

  return_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock       (clock),
    .reset       (reset),
    .push_i      (callPush),
    .pop_i       (retPop),
    .data_i      (pcPlusOne),
    .top_o       (rasTop),
    .count_o     (rasCount),
    .overflow_o  (rasOverflow),
    .underflow_o (rasUnderflow)
  );

  assign rasEmpty = (rasCount == '0);
  assign rasFull  = (rasCount == CNT_W'(RAS_DEPTH));

  // RET on an empty stack falls through rather than returning stale data.
  always_comb begin
    pcNext = pcPlusOne;
    unique case (pcSrc)
      PC_NEXT:   pcNext = pcPlusOne;
      PC_REL:    pcNext = relTarget;
      PC_ABS:    pcNext = immAddr;
      PC_RET:    pcNext = rasEmpty ? pcPlusOne : rasTop;
      PC_REG:    pcNext = mary;
      PC_CALL:   pcNext = immAddr;
      PC_BR_ABS: pcNext = comp ? immAddr : pcPlusOne;
      PC_BR_SHF: pcNext = comp ? shfTarget : pcPlusOne;
      default:   pcNext = pcPlusOne;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    rasErr_d = rasErr_q;
    if (pcWrite) begin
      pc_d     = pcNext;
      rasErr_d = rasErr_q | rasOverflow | rasUnderflow;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= RESET_VEC;
      rasErr_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rasErr_q <= rasErr_d;
    end
  end

  assign pcOut  = pc_q;
  assign rasErr = rasErr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic,
// all compared against a queue-based behavioural model.
module tb_pc_unit;
  import pc_pkg::*;

  localparam int          W     = 16;
  localparam int          DEPTH = 8;
  localparam int          SH    = 4;
  localparam logic [15:0] RVEC  = 16'h0100;

  logic          clock = 1'b0;
  logic          reset;
  logic          pcWrite;
  logic [2:0]    pcSrc;
  logic [W-1:0]  immAddr;
  logic [W-1:0]  mary;
  logic          comp;
  logic [W-1:0]  pcOut;
  logic [W-1:0]  pcNext;
  logic [3:0]    rasCount;
  logic          rasEmpty;
  logic          rasFull;
  logic          rasErr;

  int nCompared   = 0;
  int nMismatched = 0;

  // Behavioural model: the stack is a queue whose back is the most recent call.
  logic [W-1:0] mPc;
  logic [W-1:0] mStack [$];
  logic         mErr;
  logic [W-1:0] expNext;
  logic [W-1:0] obsNext;

  pc_unit #(
    .WIDTH     (W),
    .RAS_DEPTH (DEPTH),
    .SHIFT     (SH),
    .RESET_VEC (RVEC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .pcWrite  (pcWrite),
    .pcSrc    (pcSrc),
    .immAddr  (immAddr),
    .mary     (mary),
    .comp     (comp),
    .pcOut    (pcOut),
    .pcNext   (pcNext),
    .rasCount (rasCount),
    .rasEmpty (rasEmpty),
    .rasFull  (rasFull),
    .rasErr   (rasErr)
  );

  always #5 clock = ~clock;

  // One clock cycle: drive inputs, capture pcNext before the edge, then advance the model.
  task automatic step(input logic [2:0] src, input logic [W-1:0] imm, input logic [W-1:0] rv,
                      input logic c, input logic we, input logic rst);
    logic [W-1:0] plusOne;
    pcSrc = src; immAddr = imm; mary = rv; comp = c; pcWrite = we; reset = rst;
    #2;
    obsNext = pcNext;
    plusOne = mPc + 16'd1;
    case (src)
      PC_NEXT:   expNext = plusOne;
      PC_REL:    expNext = 16'(mPc + imm);
      PC_ABS:    expNext = imm;
      PC_RET:    expNext = (mStack.size() > 0) ? mStack[$] : plusOne;
      PC_REG:    expNext = rv;
      PC_CALL:   expNext = imm;
      PC_BR_ABS: expNext = c ? imm : plusOne;
      default:   expNext = c ? 16'(imm * 16) : plusOne;
    endcase
    @(posedge clock);
    if (rst) begin
      mPc = RVEC;
      mStack.delete();
      mErr = 1'b0;
    end else if (we) begin
      if (src == PC_CALL) begin
        if (mStack.size() == DEPTH) begin
          void'(mStack.pop_front());
          mErr = 1'b1;
        end
        mStack.push_back(plusOne);
      end else if (src == PC_RET) begin
        if (mStack.size() == 0) mErr = 1'b1;
        else void'(mStack.pop_back());
      end
      mPc = expNext;
    end
    #1;
  endtask

  task automatic test_reset;
    logic [15:0] expPc [3];
    expPc[0] = 16'h0101; expPc[1] = 16'h0102; expPc[2] = 16'h0103;
    step(PC_NEXT, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    nCompared++;
    if (pcOut !== 16'h0100) begin nMismatched++; $display("[TB] FAIL reset_pc: got %h expected 0100", pcOut); end
    nCompared++;
    if (rasCount !== 4'd0 || rasEmpty !== 1'b1 || rasFull !== 1'b0 || rasErr !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_ras: got cnt=%0d empty=%b full=%b err=%b expected 0/1/0/0", rasCount, rasEmpty, rasFull, rasErr);
    end
    for (int i = 0; i < 3; i++) begin
      step(PC_NEXT, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
      nCompared++;
      if (pcOut !== expPc[i] || rasEmpty !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL next_%0d: got pc=%h empty=%b expected pc=%h empty=1", i, pcOut, rasEmpty, expPc[i]);
      end
    end
  endtask

  task automatic test_call_ret;
    step(PC_ABS, 16'h0010, 16'h0, 1'b0, 1'b1, 1'b0);
    step(PC_CALL, 16'h0200, 16'h0, 1'b0, 1'b1, 1'b0);
    nCompared++;
    if (pcOut !== 16'h0200 || rasCount !== 4'd1) begin
      nMismatched++;
      $display("[TB] FAIL call: got pc=%h cnt=%0d expected pc=0200 cnt=1", pcOut, rasCount);
    end
    step(PC_RET, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    nCompared++;
    if (obsNext !== 16'h0011) begin nMismatched++; $display("[TB] FAIL ret_next: got %h expected 0011", obsNext); end
    nCompared++;
    if (pcOut !== 16'h0011 || rasCount !== 4'd0 || rasErr !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ret: got pc=%h cnt=%0d err=%b expected pc=0011 cnt=0 err=0", pcOut, rasCount, rasErr);
    end
  endtask

  task automatic test_nested;
    logic [15:0] retAddr [9];
    step(PC_ABS, 16'h1000, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      retAddr[i] = pcOut + 16'd1;
      step(PC_CALL, 16'(16'h2000 + i * 16'h0010), 16'h0, 1'b0, 1'b1, 1'b0);
    end
    nCompared++;
    if (rasFull !== 1'b1 || rasErr !== 1'b1 || rasCount !== 4'd8) begin
      nMismatched++;
      $display("[TB] FAIL nested_full: got full=%b err=%b cnt=%0d expected 1/1/8", rasFull, rasErr, rasCount);
    end
    for (int i = 0; i < 8; i++) begin
      step(PC_RET, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
      nCompared++;
      if (pcOut !== retAddr[8 - i]) begin
        nMismatched++;
        $display("[TB] FAIL nested_ret_%0d: got %h expected %h", i + 1, pcOut, retAddr[8 - i]);
      end
    end
    begin
      logic [15:0] fall;
      fall = pcOut + 16'd1;
      step(PC_RET, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
      nCompared++;
      if (pcOut !== fall || rasCount !== 4'd0 || rasEmpty !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL nested_ret_9: got pc=%h cnt=%0d expected pc=%h cnt=0", pcOut, rasCount, fall);
      end
    end
  endtask

  task automatic test_br_shf;
    step(PC_ABS, 16'h0005, 16'h0, 1'b0, 1'b1, 1'b0);
    step(PC_BR_SHF, 16'h0FFF, 16'h0, 1'b1, 1'b1, 1'b0);
    nCompared++;
    if (pcOut !== 16'hFFF0) begin nMismatched++; $display("[TB] FAIL br_shf_taken: got %h expected fff0", pcOut); end
    step(PC_ABS, 16'h0005, 16'h0, 1'b0, 1'b1, 1'b0);
    step(PC_BR_SHF, 16'h0FFF, 16'h0, 1'b0, 1'b1, 1'b0);
    nCompared++;
    if (pcOut !== 16'h0006) begin nMismatched++; $display("[TB] FAIL br_shf_untaken: got %h expected 0006", pcOut); end
    step(PC_BR_ABS, 16'h4321, 16'h0, 1'b1, 1'b1, 1'b0);
    nCompared++;
    if (pcOut !== 16'h4321) begin nMismatched++; $display("[TB] FAIL br_abs_taken: got %h expected 4321", pcOut); end
  endtask

  task automatic test_rel;
    step(PC_ABS, 16'hFFFE, 16'h0, 1'b0, 1'b1, 1'b0);
    step(PC_REL, 16'h0003, 16'h0, 1'b0, 1'b1, 1'b0);
    nCompared++;
    if (pcOut !== 16'h0001) begin nMismatched++; $display("[TB] FAIL rel_wrap_up: got %h expected 0001", pcOut); end
    step(PC_ABS, 16'h0000, 16'h0, 1'b0, 1'b1, 1'b0);
    step(PC_REL, 16'hFFFF, 16'h0, 1'b0, 1'b1, 1'b0);
    nCompared++;
    if (pcOut !== 16'hFFFF) begin nMismatched++; $display("[TB] FAIL rel_wrap_down: got %h expected ffff", pcOut); end
    step(PC_REG, 16'h0, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    nCompared++;
    if (pcOut !== 16'hBEEF) begin nMismatched++; $display("[TB] FAIL reg: got %h expected beef", pcOut); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] base;
    step(PC_ABS, 16'h0300, 16'h0, 1'b0, 1'b1, 1'b0);
    step(PC_CALL, 16'h0800, 16'h0, 1'b0, 1'b1, 1'b0);
    step(PC_RET, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    nCompared++;
    if (pcOut !== 16'h0301) begin nMismatched++; $display("[TB] FAIL b2b_ret: got %h expected 0301", pcOut); end
    base = pcOut;
    step(PC_CALL, 16'h0900, 16'h0, 1'b0, 1'b1, 1'b0);
    step(PC_CALL, 16'h0A00, 16'h0, 1'b0, 1'b1, 1'b0);
    step(PC_RET, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    nCompared++;
    if (pcOut !== 16'h0901) begin nMismatched++; $display("[TB] FAIL b2b_inner: got %h expected 0901", pcOut); end
    step(PC_RET, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    nCompared++;
    if (pcOut !== 16'(base + 16'd1)) begin nMismatched++; $display("[TB] FAIL b2b_outer: got %h expected %h", pcOut, 16'(base + 16'd1)); end
  endtask

  task automatic test_stall_reset;
    step(PC_ABS, 16'h0040, 16'h0, 1'b0, 1'b1, 1'b0);
    step(PC_CALL, 16'h0300, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(PC_CALL, 16'h0500, 16'h0, 1'b0, 1'b0, 1'b0);
      nCompared++;
      if (obsNext !== 16'h0500) begin nMismatched++; $display("[TB] FAIL stall_next_%0d: got %h expected 0500", i, obsNext); end
      nCompared++;
      if (pcOut !== 16'h0300 || rasCount !== 4'd1) begin
        nMismatched++;
        $display("[TB] FAIL stall_hold_%0d: got pc=%h cnt=%0d expected pc=0300 cnt=1", i, pcOut, rasCount);
      end
    end
    step(PC_CALL, 16'h0500, 16'h0, 1'b0, 1'b1, 1'b1);
    nCompared++;
    if (pcOut !== RVEC || rasCount !== 4'd0 || rasEmpty !== 1'b1 || rasErr !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_wins: got pc=%h cnt=%0d empty=%b err=%b expected pc=0100 cnt=0 empty=1 err=0",
               pcOut, rasCount, rasEmpty, rasErr);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      step(3'($urandom_range(7)), 16'($urandom), 16'($urandom), 1'($urandom),
           ($urandom_range(3) != 0), 1'b0);
      nCompared++;
      if (obsNext !== expNext) begin nMismatched++; $display("[TB] FAIL rand_next_%0d: got %h expected %h", i, obsNext, expNext); end
      nCompared++;
      if (pcOut !== mPc) begin nMismatched++; $display("[TB] FAIL rand_pc_%0d: got %h expected %h", i, pcOut, mPc); end
      nCompared++;
      if (rasCount !== 4'(mStack.size()) || rasEmpty !== (mStack.size() == 0) ||
          rasFull !== (mStack.size() == DEPTH) || rasErr !== mErr) begin
        nMismatched++;
        $display("[TB] FAIL rand_ras_%0d: got cnt=%0d empty=%b full=%b err=%b expected cnt=%0d err=%b",
                 i, rasCount, rasEmpty, rasFull, rasErr, mStack.size(), mErr);
      end
    end
  endtask

  initial begin
    mPc = RVEC; mErr = 1'b0;
    reset = 1'b1; pcWrite = 1'b0; pcSrc = PC_NEXT; immAddr = '0; mary = '0; comp = 1'b0;
    test_reset();
    test_call_ret();
    test_nested();
    test_br_shf();
    test_rel();
    test_back_to_back();
    test_stall_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
